// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic single-transfer master driven by a valid/ready command stream
// Optional feature macro: WB_CMD_MASTER_RETRY_EN (re-issue a timed-out command up to twice).
`timescale 1ns/1ps
module wb_cmd_master #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_we,
    input  logic [AW-1:0] i_cmd_adr,
    input  logic [DW-1:0] i_cmd_data,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [DW-1:0] o_rsp_data,
    output logic          o_rsp_err,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_adr,
    output logic [DW-1:0] o_wb_data,
    input  logic          i_wb_ack,
    input  logic [DW-1:0] i_wb_data
);

`ifdef WB_CMD_MASTER_RETRY_EN
    typedef enum logic [2:0] {IDLE, BUS, RESP, DRAIN, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUS, RESP, DRAIN} state_t;
`endif

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          cyc_d, stb_d, we_d;
    logic [AW-1:0] adr_d;
    logic [DW-1:0] wdata_d;
    logic          rsp_valid_d, rsp_err_d;
    logic [DW-1:0] rsp_data_d;
`ifdef WB_CMD_MASTER_RETRY_EN
    logic          cmd_we_q, cmd_we_d;
    logic [1:0]    tries_q, tries_d;
`endif

    // Gated by reset so the master never advertises readiness while held in reset.
    assign o_cmd_ready = (state_q == IDLE) && !i_wb_ack && i_rst;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_adr    <= '0;
            o_wb_data   <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
`ifdef WB_CMD_MASTER_RETRY_EN
            cmd_we_q    <= 1'b0;
            tries_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            o_wb_cyc    <= cyc_d;
            o_wb_stb    <= stb_d;
            o_wb_we     <= we_d;
            o_wb_adr    <= adr_d;
            o_wb_data   <= wdata_d;
            o_rsp_valid <= rsp_valid_d;
            o_rsp_data  <= rsp_data_d;
            o_rsp_err   <= rsp_err_d;
`ifdef WB_CMD_MASTER_RETRY_EN
            cmd_we_q    <= cmd_we_d;
            tries_q     <= tries_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = o_wb_cyc;
        stb_d       = o_wb_stb;
        we_d        = o_wb_we;
        adr_d       = o_wb_adr;
        wdata_d     = o_wb_data;
        rsp_valid_d = o_rsp_valid;
        rsp_data_d  = o_rsp_data;
        rsp_err_d   = o_rsp_err;
`ifdef WB_CMD_MASTER_RETRY_EN
        cmd_we_d    = cmd_we_q;
        tries_d     = tries_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_cmd_valid && o_cmd_ready) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = i_cmd_we;
                    adr_d   = i_cmd_adr;
                    wdata_d = i_cmd_data;
                    cnt_d   = '0;
`ifdef WB_CMD_MASTER_RETRY_EN
                    cmd_we_d = i_cmd_we;
                    tries_d  = 2'd0;
`endif
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack is checked first so a last-cycle ack still completes the transfer.
                if (i_wb_ack) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_data_d  = o_wb_we ? '0 : i_wb_data;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
`ifdef WB_CMD_MASTER_RETRY_EN
                    if (tries_q != 2'd2) begin
                        tries_d = tries_q + 2'd1;
                        state_d = GAP;
                    end else begin
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
`else
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef WB_CMD_MASTER_RETRY_EN
            GAP: begin
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = cmd_we_q;
                cnt_d   = '0;
                state_d = BUS;
            end
`endif
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                // Slaves may hold ack until they see stb low; wait it out before the next command.
                if (!i_wb_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - directed self-checking bench for wb_cmd_master with a register-file slave
`timescale 1ns/1ps
module tb_wb_cmd_master;
    localparam int TO = 16;
`ifdef WB_CMD_MASTER_RETRY_EN
    localparam int EXP_CYC = 48;
    localparam int EXP_ATT = 3;
`else
    localparam int EXP_CYC = 16;
    localparam int EXP_ATT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [15:0] cmd_adr = '0, cmd_data = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [15:0] rsp_data;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [15:0] wb_adr, wb_wdata, wb_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.AW(16), .DW(16), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_adr(cmd_adr), .i_cmd_data(cmd_data),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_adr(wb_adr), .o_wb_data(wb_wdata),
        .i_wb_ack(wb_ack), .i_wb_data(wb_rdata)
    );

    // Slave: 8 x 16-bit registers; registered ack held while stb is high plus extra_hold cycles.
    logic [15:0] mem [0:7];
    logic        ack_r = 1'b0;
    logic        ack_en = 1'b1;
    logic        comb_ack = 1'b0;
    int          extra_hold = 0;
    int          hold_cnt = 0;

    assign wb_ack   = comb_ack ? (wb_cyc && wb_stb) : ack_r;
    assign wb_rdata = mem[wb_adr[3:1]];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
            ack_r    <= 1'b0;
            hold_cnt <= 0;
        end else if (ack_en && wb_cyc && wb_stb) begin
            ack_r    <= !comb_ack;
            hold_cnt <= extra_hold;
            if (wb_we) mem[wb_adr[3:1]] <= wb_wdata;
        end else if (ack_r && hold_cnt > 0) begin
            hold_cnt <= hold_cnt - 1;
        end else begin
            ack_r <= 1'b0;
        end
    end

    task automatic do_cmd(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                          output logic [15:0] rd, output logic er, output logic ok);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_data = dat;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        ok = rsp_valid; rd = rsp_data; er = rsp_err;
    endtask

    task automatic test_reset;
        #12;
        checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0) begin
            errors++; $display("FAIL reset_wb_ctl: got cyc=%b stb=%b we=%b expected 000", wb_cyc, wb_stb, wb_we); end
        checks++; if (wb_adr !== 16'h0 || wb_wdata !== 16'h0) begin
            errors++; $display("FAIL reset_wb_bus: got adr=%h data=%h expected 0000 0000", wb_adr, wb_wdata); end
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: got v=%b d=%h e=%b expected 0 0000 0", rsp_valid, rsp_data, rsp_err); end
        checks++; if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_writes;
        logic [15:0] adrs [3] = '{16'h0004, 16'h0006, 16'h0000};
        logic [15:0] dats [3] = '{16'h0008, 16'h0006, 16'h0016};
        logic [15:0] rd; logic er, ok;
        for (int i = 0; i < 3; i++) begin
            do_cmd(1'b1, adrs[i], dats[i], rd, er, ok);
            checks++; if (ok !== 1'b1 || er !== 1'b0 || rd !== 16'h0) begin
                errors++; $display("FAIL write_rsp%0d: got ok=%b err=%b data=%h expected 1 0 0000", i, ok, er, rd); end
            checks++; if (wb_adr !== adrs[i] || wb_wdata !== dats[i] || wb_we !== 1'b0) begin
                errors++; $display("FAIL write_bus%0d: got adr=%h data=%h we=%b expected %h %h 0",
                                   i, wb_adr, wb_wdata, wb_we, adrs[i], dats[i]); end
        end
        checks++; if (mem[2] !== 16'h0008 || mem[3] !== 16'h0006 || mem[0] !== 16'h0016) begin
            errors++; $display("FAIL write_regs: got %h %h %h expected 0008 0006 0016", mem[2], mem[3], mem[0]); end
    endtask

    task automatic test_read;
        logic [15:0] rd; logic er, ok;
        do_cmd(1'b0, 16'h0004, 16'hFFFF, rd, er, ok);
        checks++; if (ok !== 1'b1 || er !== 1'b0 || rd !== 16'h0008) begin
            errors++; $display("FAIL read_0004: got ok=%b err=%b data=%h expected 1 0 0008", ok, er, rd); end
        checks++; if (wb_cyc !== 1'b0) begin
            errors++; $display("FAIL read_cyc_low: got %b expected 0", wb_cyc); end
        do_cmd(1'b0, 16'h0000, 16'h0000, rd, er, ok);
        checks++; if (rd !== 16'h0016 || er !== 1'b0) begin
            errors++; $display("FAIL read_0000: got err=%b data=%h expected 0 0016", er, rd); end
    endtask

    task automatic test_timeout;
        int n, cyc_n, att; logic prev;
        ack_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 16'h0008;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0; cyc_n = 0; att = 0; prev = 1'b0;
        while (!rsp_valid && n < 400) begin
            if (wb_cyc) cyc_n++;
            if (wb_cyc && !prev) att++;
            prev = wb_cyc;
            @(negedge clk); n++;
        end
        checks++; if (cyc_n != EXP_CYC) begin
            errors++; $display("FAIL timeout_cyc_cycles: got %0d expected %0d", cyc_n, EXP_CYC); end
        checks++; if (att != EXP_ATT) begin
            errors++; $display("FAIL timeout_attempts: got %0d expected %0d", att, EXP_ATT); end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0) begin
            errors++; $display("FAIL timeout_rsp: got v=%b e=%b d=%h expected 1 1 0000", rsp_valid, rsp_err, rsp_data); end
        ack_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rsp_hold;
        int n; logic bad;
        logic [15:0] rd; logic er, ok;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 16'h0006;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_we = 1'b1; cmd_adr = 16'h000A; cmd_data = 16'h0055;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h0006 || rsp_err !== 1'b0 ||
                cmd_ready !== 1'b0 || wb_cyc !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad !== 1'b0) begin
            errors++; $display("FAIL rsp_hold_stable: got v=%b d=%h e=%b rdy=%b cyc=%b expected 1 0006 0 0 0",
                               rsp_valid, rsp_data, rsp_err, cmd_ready, wb_cyc); end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        do_cmd(1'b1, 16'h000A, 16'h0055, rd, er, ok);
        checks++; if (ok !== 1'b1 || er !== 1'b0 || mem[5] !== 16'h0055) begin
            errors++; $display("FAIL after_hold_write: got ok=%b err=%b reg=%h expected 1 0 0055", ok, er, mem[5]); end
    endtask

    task automatic test_drain;
        int n, ack_n; logic bad;
        logic [15:0] rd; logic er, ok;
        extra_hold = 3;
        do_cmd(1'b1, 16'h000C, 16'h0077, rd, er, ok);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 16'h000E; cmd_data = 16'h0099;
        ack_n = 0; bad = 1'b0; n = 0;
        while (wb_ack && n < 20) begin
            if (cmd_ready !== 1'b0 || wb_cyc !== 1'b0) bad = 1'b1;
            ack_n++;
            @(negedge clk); n++;
        end
        checks++; if (bad !== 1'b0) begin
            errors++; $display("FAIL drain_blocks_cmd: got rdy=%b cyc=%b expected 0 0", cmd_ready, wb_cyc); end
        checks++; if (ack_n != 4) begin
            errors++; $display("FAIL drain_ack_cycles: got %0d expected 4", ack_n); end
        extra_hold = 0;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || mem[7] !== 16'h0099 || mem[6] !== 16'h0077) begin
            errors++; $display("FAIL drain_queued_cmd: got v=%b e=%b regs=%h %h expected 1 0 0077 0099",
                               rsp_valid, rsp_err, mem[6], mem[7]); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int idx [$];
        comb_ack = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 16'h0002; cmd_data = 16'h0011;
        for (int i = 0; i < 13; i++) begin
            if (cmd_ready) idx.push_back(i);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++; if (idx.size() < 3) begin
            errors++; $display("FAIL b2b_count: got %0d expected >=3", idx.size()); end
        else begin
            checks++; if (idx[1] - idx[0] != 4 || idx[2] - idx[1] != 4) begin
                errors++; $display("FAIL b2b_spacing: got %0d %0d expected 4 4", idx[1] - idx[0], idx[2] - idx[1]); end
        end
        repeat (6) @(negedge clk);
        comb_ack = 1'b0;
        checks++; if (mem[1] !== 16'h0011) begin
            errors++; $display("FAIL b2b_reg: got %h expected 0011", mem[1]); end
    endtask

    task automatic test_reset_mid;
        int n; logic bad;
        logic [15:0] rd; logic er, ok;
        ack_en = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 16'h0004; cmd_data = 16'h1234;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (wb_cyc !== 1'b1) begin
            errors++; $display("FAIL mid_bus_cyc: got %b expected 1", wb_cyc); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: got cyc=%b stb=%b v=%b expected 0 0 0", wb_cyc, wb_stb, rsp_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        bad = 1'b0;
        repeat (4) begin @(negedge clk); if (rsp_valid !== 1'b0) bad = 1'b1; end
        checks++; if (bad !== 1'b0) begin
            errors++; $display("FAIL no_rsp_after_reset: got %b expected 0", bad); end
        do_cmd(1'b1, 16'h0004, 16'h000A, rd, er, ok);
        checks++; if (ok !== 1'b1 || er !== 1'b0) begin
            errors++; $display("FAIL post_reset_write: got ok=%b err=%b expected 1 0", ok, er); end
        do_cmd(1'b0, 16'h0004, 16'h0000, rd, er, ok);
        checks++; if (rd !== 16'h000A || er !== 1'b0) begin
            errors++; $display("FAIL post_reset_read: got err=%b data=%h expected 0 000a", er, rd); end
    endtask

    initial begin
        test_reset();
        test_writes();
        test_read();
        test_timeout();
        test_rsp_hold();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
